mbus_ctrl_bcast_tx: RTL and testbench
=====================================

Name: mbus_ctrl_bcast_tx

Overview:
- Transmit-side companion to the master-node control-channel interceptor. The interceptor auto-acknowledges received control broadcasts; this block originates them.
- Accepts a 1–4 word control command from the local controller and drives the master node's TX handshake with a broadcast address on CHANNEL_CTRL.
- Handles the four-phase TX_REQ/TX_ACK and TX_SUCC/TX_FAIL/TX_RESP_ACK handshakes, with bounded retry on failure.
- Sits between the CPU-layer command source and the TX port of the master mbus_node.

Parameters:
- MAX_RETRY, 2: retransmissions after the first attempt before reporting an error.
- RETRY_GAP, 16: idle cycles between a failure response and the next attempt (must be ≥1).
- TIMEOUT_CYCLES, 1024: result watchdog limit; used only with the optional feature.

Ports:
- CLK_EXT  in  1  system clock.
- RESETn_local  in  1  asynchronous, active-low reset.
- CMD_REQ  in  1  command request (level).
- CMD_LEN  in  2  number of words minus 1 (0 = 1 word … 3 = 4 words).
- CMD_DATA  in  4*DATA_WIDTH  payload; word k = CMD_DATA[k*DATA_WIDTH +: DATA_WIDTH], word 0 sent first.
- CMD_PRIORITY  in  1  request priority arbitration.
- CMD_ACK  out  1  one-cycle pulse when the command is latched.
- CMD_DONE  out  1  one-cycle pulse on TX_SUCC completion.
- CMD_ERR  out  1  one-cycle pulse on retries exhausted or timeout.
- BUSY  out  1  high in any state other than IDLE.
- TX_ADDR  out  ADDR_WIDTH  broadcast address.
- TX_DATA  out  DATA_WIDTH  current word.
- TX_PEND  out  1  more words follow the current word.
- TX_REQ  out  1  word request.
- TX_PRIORITY  out  1  latched CMD_PRIORITY.
- TX_ACK  in  1  node word acknowledge.
- TX_SUCC  in  1  node success result.
- TX_FAIL  in  1  node failure result.
- TX_RESP_ACK  out  1  result acknowledge.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; word index, retry count and gap counter cleared.
- Reset is asynchronous and may assert in any state, including mid-transfer. Outputs drop to 0 immediately and no CMD_DONE or CMD_ERR is issued.
- TX_ADDR is constant: CHANNEL_CTRL in bits [FUNC_WIDTH-1:0], all other bits 0 (short broadcast prefix).
- TX_DATA is the word selected by the index. TX_PEND = (index != latched length).
- IDLE:
  - When CMD_REQ=1, latch CMD_LEN, CMD_DATA and CMD_PRIORITY; pulse CMD_ACK; index=0; retry=0; go to SEND.
  - First TX_REQ rises the cycle after CMD_ACK.
  - CMD_REQ is ignored whenever BUSY=1. The latched payload is immune to later changes on CMD_DATA.
- SEND: TX_REQ=1. On TX_ACK=1, drop TX_REQ and go to ACK_LOW.
- ACK_LOW: TX_REQ=0. When TX_ACK=0:
  - if TX_PEND was 1: index+1, go to SEND;
  - else go to WAIT_RES.
- Word timing: a new TX_REQ never rises while TX_ACK is high, so the minimum word period is 2 cycles plus node latency.
- WAIT_RES:
  - TX_SUCC=1: TX_RESP_ACK=1, record success, go to RESP.
  - TX_FAIL=1: TX_RESP_ACK=1, record failure, go to RESP.
  - Both asserted in the same cycle: treated as failure.
- TX_FAIL may also arrive in SEND or ACK_LOW (arbitration lost or bus error). Drop TX_REQ, assert TX_RESP_ACK, record failure, go to RESP.
- RESP: hold TX_RESP_ACK until TX_SUCC and TX_FAIL are both 0, then drop it.
  - Success: pulse CMD_DONE, go to IDLE.
  - Failure with retry < MAX_RETRY: retry+1, load gap counter = RETRY_GAP, go to GAP.
  - Failure with retry == MAX_RETRY: pulse CMD_ERR, go to IDLE.
- GAP: decrement the gap counter each cycle. At 0: index=0, go to SEND. Every retry resends the full command from word 0.
- Total attempts = MAX_RETRY+1. Counter widths are sized by $clog2 of the parameters plus 1.

Optional Feature:
- Macro: MBUS_CTRL_BCAST_TIMEOUT_EN.
- Defined:
  - A counter clears on entering SEND and increments in SEND, ACK_LOW and WAIT_RES.
  - On reaching TIMEOUT_CYCLES: force TX_REQ=0 and TX_RESP_ACK=0, pulse CMD_ERR, go to IDLE with no retry.
  - Any TX_ACK, TX_SUCC or TX_FAIL still high is ignored until it deasserts; IDLE does not accept a new command while any of them is 1.
- Undefined: no counter; the block waits indefinitely.

Test Plan:
- 1-word success: CMD_LEN=0, word0=32'hA5A5_0001.
  - Expect one TX_REQ with TX_PEND=0 and TX_ADDR low nibble = CHANNEL_CTRL.
  - Node returns TX_SUCC → TX_RESP_ACK, then one CMD_DONE pulse, BUSY=0.
- 4-word success: CMD_LEN=3, words 1,2,3,4.
  - Expect four TX_REQ/TX_ACK cycles with TX_DATA 1,2,3,4 and TX_PEND 1,1,1,0.
  - Then CMD_DONE.
- Fail then succeed (MAX_RETRY=2, RETRY_GAP=16):
  - First attempt gets TX_FAIL → exactly 16 idle cycles after TX_RESP_ACK falls.
  - Word 0 resent; TX_SUCC → CMD_DONE, no CMD_ERR.
- Retries exhausted: TX_FAIL on every attempt.
  - Expect exactly 3 attempts, then one CMD_ERR pulse, no CMD_DONE.
- Reset mid-transfer: assert RESETn_local=0 during word 2 of a 4-word command.
  - All outputs 0 immediately, no CMD_DONE or CMD_ERR.
  - A fresh command after reset completes normally.
- Busy rejection and timeout:
  - A CMD_REQ pulse while BUSY produces no CMD_ACK.
  - With MBUS_CTRL_BCAST_TIMEOUT_EN, TIMEOUT_CYCLES=64 and a node that never responds: CMD_ERR exactly 64 cycles after entering SEND.

Source files
------------

// File: rtl/mbus_ctrl_bcast_tx_if.sv
// mbus_ctrl_bcast_tx_if: command-side and master-node TX-side signals of the control broadcast transmitter.
interface mbus_ctrl_bcast_tx_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                    CMD_REQ;
  logic [1:0]              CMD_LEN;
  logic [4*DATA_WIDTH-1:0] CMD_DATA;
  logic                    CMD_PRIORITY;
  logic                    CMD_ACK;
  logic                    CMD_DONE;
  logic                    CMD_ERR;
  logic                    BUSY;
  logic [ADDR_WIDTH-1:0]   TX_ADDR;
  logic [DATA_WIDTH-1:0]   TX_DATA;
  logic                    TX_PEND;
  logic                    TX_REQ;
  logic                    TX_PRIORITY;
  logic                    TX_ACK;
  logic                    TX_SUCC;
  logic                    TX_FAIL;
  logic                    TX_RESP_ACK;
  modport master (
    input  CMD_REQ, CMD_LEN, CMD_DATA, CMD_PRIORITY, TX_ACK, TX_SUCC, TX_FAIL,
    output CMD_ACK, CMD_DONE, CMD_ERR, BUSY, TX_ADDR, TX_DATA, TX_PEND, TX_REQ, TX_PRIORITY, TX_RESP_ACK
  );
  modport slave (
    output CMD_REQ, CMD_LEN, CMD_DATA, CMD_PRIORITY, TX_ACK, TX_SUCC, TX_FAIL,
    input  CMD_ACK, CMD_DONE, CMD_ERR, BUSY, TX_ADDR, TX_DATA, TX_PEND, TX_REQ, TX_PRIORITY, TX_RESP_ACK
  );
endinterface

// File: rtl/mbus_ctrl_bcast_tx.sv
// mbus_ctrl_bcast_tx: originates 1-4 word control broadcasts on the master node TX port with bounded retry.
// Optional result watchdog enabled by defining MBUS_CTRL_BCAST_TIMEOUT_EN.
module mbus_ctrl_bcast_tx #(
  parameter int                    ADDR_WIDTH     = 8,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    FUNC_WIDTH     = 4,
  parameter logic [FUNC_WIDTH-1:0] CHANNEL_CTRL   = FUNC_WIDTH'(1),
  parameter int                    MAX_RETRY      = 2,
  parameter int                    RETRY_GAP      = 16,
  parameter int                    TIMEOUT_CYCLES = 1024
) (
  input logic                 CLK_EXT,
  input logic                 RESETn_local,
  mbus_ctrl_bcast_tx_if.master bus
);
  localparam int RW = $clog2(MAX_RETRY + 1) + 1;
  localparam int GW = $clog2(RETRY_GAP + 1) + 1;
  typedef enum logic [2:0] {IDLE, SEND, ACK_LOW, WAIT_RES, RESP, GAP} state_t;
  state_t                state_q, state_d;
  logic [1:0]            len_q, len_d, idx_q, idx_d;
  logic [DATA_WIDTH-1:0] data_q [4];
  logic [DATA_WIDTH-1:0] data_d [4];
  logic [DATA_WIDTH-1:0] cmd_w [4];
  logic                  pri_q, pri_d, ok_q, ok_d;
  logic [RW-1:0]         retry_q, retry_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic                  cmd_ack, cmd_done, cmd_err, tmo, idle_ok, res;
  for (genvar g = 0; g < 4; g++) begin : g_w
    assign cmd_w[g] = bus.CMD_DATA[g*DATA_WIDTH +: DATA_WIDTH];
  end
  assign res = bus.TX_SUCC || bus.TX_FAIL;
  always_ff @(posedge CLK_EXT or negedge RESETn_local) begin
    if (!RESETn_local) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      data_q  <= '{default: '0};
      pri_q   <= 1'b0;
      ok_q    <= 1'b0;
      retry_q <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      pri_q   <= pri_d;
      ok_q    <= ok_d;
      retry_q <= retry_d;
      gap_q   <= gap_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    data_d   = data_q;
    pri_d    = pri_q;
    ok_d     = ok_q;
    retry_d  = retry_q;
    gap_d    = gap_q;
    cmd_ack  = 1'b0;
    cmd_done = 1'b0;
    cmd_err  = 1'b0;
    case (state_q)
      IDLE: if (bus.CMD_REQ && idle_ok) begin
        cmd_ack = 1'b1;
        len_d   = bus.CMD_LEN;
        data_d  = cmd_w;
        pri_d   = bus.CMD_PRIORITY;
        idx_d   = '0;
        retry_d = '0;
        state_d = SEND;
      end
      // a failure during the word phase means arbitration was lost or the bus errored
      SEND: begin
        ok_d    = bus.TX_FAIL ? 1'b0 : ok_q;
        state_d = bus.TX_FAIL ? RESP : bus.TX_ACK ? ACK_LOW : SEND;
      end
      ACK_LOW: begin
        ok_d    = bus.TX_FAIL ? 1'b0 : ok_q;
        idx_d   = (!bus.TX_FAIL && !bus.TX_ACK && idx_q != len_q) ? idx_q + 2'd1 : idx_q;
        state_d = bus.TX_FAIL ? RESP : bus.TX_ACK ? ACK_LOW : (idx_q != len_q) ? SEND : WAIT_RES;
      end
      WAIT_RES: begin
        ok_d    = res ? !bus.TX_FAIL : ok_q;
        state_d = res ? RESP : WAIT_RES;
      end
      RESP: if (!res) begin
        cmd_done = ok_q;
        cmd_err  = !ok_q && retry_q == RW'(MAX_RETRY);
        retry_d  = (ok_q || cmd_err) ? retry_q : retry_q + RW'(1);
        gap_d    = GW'(RETRY_GAP);
        state_d  = (ok_q || cmd_err) ? IDLE : GAP;
      end
      GAP: begin
        gap_d   = gap_q - GW'(1);
        idx_d   = '0;
        state_d = (gap_q == GW'(1)) ? SEND : GAP;
      end
      default: state_d = IDLE;
    endcase
    if (tmo) begin
      cmd_err = 1'b1;
      state_d = IDLE;
    end
  end
`ifdef MBUS_CTRL_BCAST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1) + 1;
  logic [TW-1:0] to_q, to_d;
  logic          active;
  assign active  = state_q inside {SEND, ACK_LOW, WAIT_RES};
  assign tmo     = active && to_q == TW'(TIMEOUT_CYCLES);
  // stale node strobes from an abandoned transfer must clear before a new command
  assign idle_ok = !(bus.TX_ACK || bus.TX_SUCC || bus.TX_FAIL);
  assign to_d    = (state_d == SEND && state_q != SEND) ? '0 : active ? to_q + TW'(1) : '0;
  always_ff @(posedge CLK_EXT or negedge RESETn_local) begin
    if (!RESETn_local) to_q <= '0;
    else to_q <= to_d;
  end
`else
  logic unused_timeout;
  assign tmo            = 1'b0;
  assign idle_ok        = 1'b1;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif
  assign bus.CMD_ACK     = cmd_ack;
  assign bus.CMD_DONE    = cmd_done;
  assign bus.CMD_ERR     = cmd_err;
  assign bus.BUSY        = state_q != IDLE;
  assign bus.TX_ADDR     = {{(ADDR_WIDTH-FUNC_WIDTH){1'b0}}, CHANNEL_CTRL};
  assign bus.TX_DATA     = data_q[idx_q];
  assign bus.TX_PEND     = idx_q != len_q;
  assign bus.TX_REQ      = state_q == SEND && !tmo;
  assign bus.TX_PRIORITY = pri_q;
  assign bus.TX_RESP_ACK = state_q == RESP;
endmodule

// File: tb/tb_mbus_ctrl_bcast_tx.sv
// tb_mbus_ctrl_bcast_tx: randomized node responder checked against a transaction-level outcome model.
`timescale 1ns/1ps
module tb_mbus_ctrl_bcast_tx;
  localparam int AW = 8, DW = 32, MAXR = 2, GAPC = 16, TMO = 64;
  localparam logic [AW-1:0] EXP_ADDR = 8'h01;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  mbus_ctrl_bcast_tx_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b ();
  mbus_ctrl_bcast_tx #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FUNC_WIDTH(4), .CHANNEL_CTRL(4'h1),
    .MAX_RETRY(MAXR), .RETRY_GAP(GAPC), .TIMEOUT_CYCLES(TMO)
  ) dut (.CLK_EXT(clk), .RESETn_local(rstn), .bus(b.master));

  int tests = 0, fails = 0;
  int n_ack = 0, n_done = 0, n_err = 0, n_rise = 0;
  logic exp_on = 1'b0;
  logic [DW-1:0] exp_data = '0;
  logic exp_pend = 1'b0, exp_pri = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic sig(input int k);
    return k == 0 ? b.TX_REQ : k == 1 ? !b.TX_REQ : k == 2 ? b.TX_RESP_ACK :
           k == 3 ? !b.TX_RESP_ACK : k == 4 ? b.CMD_ACK : b.CMD_ERR;
  endfunction

  task automatic wait_sig(input int k, input string nm, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sig(k) && n < 400);
    if (!sig(k)) begin
      tests++;
      fails++;
      $display("FAIL %s: no event within %0d cycles", nm, n);
    end
  endtask

  task automatic drv();
    @(posedge clk);
    #1;
  endtask

  // every cycle: word contents whenever a word is offered, plus pulse counting
  initial begin
    logic prev_req;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (b.CMD_ACK) n_ack++;
        if (b.CMD_DONE) n_done++;
        if (b.CMD_ERR) n_err++;
        if (b.TX_REQ && !prev_req) begin
          n_rise++;
          chk("req_rise_with_ack_low", 64'(b.TX_ACK), 64'(0));
        end
        if (b.TX_REQ) begin
          chk("req_expected", 64'(exp_on), 64'(1));
          chk("tx_data", 64'(b.TX_DATA), 64'(exp_data));
          chk("tx_pend", 64'(b.TX_PEND), 64'(exp_pend));
          chk("tx_priority", 64'(b.TX_PRIORITY), 64'(exp_pri));
          chk("tx_addr", 64'(b.TX_ADDR), 64'(EXP_ADDR));
        end
      end
      prev_req = b.TX_REQ;
    end
  end

  // res per attempt: 0 success, 1 fail at result, 2 succ+fail together, 3 fail during word fw
  task automatic run_cmd(input int len, input logic [4*DW-1:0] data, input logic pri,
                         input int res [3], input int fw [3], input bit poke);
    int n, att, a0, d0, e0, r0, rises;
    bit ok, mid;
    logic [DW-1:0] w [4];
    for (int i = 0; i < 4; i++) w[i] = data[i*DW +: DW];
    att = MAXR + 1;
    ok = 0;
    for (int i = 0; i <= MAXR; i++) if (res[i] == 0 && !ok) begin ok = 1; att = i + 1; end
    rises = 0;
    for (int i = 0; i < att; i++) rises += (res[i] == 3) ? fw[i] + 1 : len + 1;
    a0 = n_ack; d0 = n_done; e0 = n_err; r0 = n_rise;
    exp_pri = pri;
    exp_data = w[0];
    exp_pend = len != 0;
    exp_on = 1'b1;
    drv();
    b.CMD_REQ = 1'b1; b.CMD_LEN = 2'(len); b.CMD_DATA = data; b.CMD_PRIORITY = pri;
    wait_sig(4, "cmd_ack", n);
    drv();
    b.CMD_REQ = 1'b0; b.CMD_DATA = {4{$urandom()}}; b.CMD_PRIORITY = !pri; b.CMD_LEN = 2'($urandom());
    for (int a = 0; a < att; a++) begin
      mid = 0;
      for (int i = 0; i <= len && !mid; i++) begin
        exp_data = w[i];
        exp_pend = i != len;
        wait_sig(0, "tx_req", n);
        if (a == 0 && i == 0) chk("first_req_after_ack", 64'(n), 64'(1));
        if (a > 0 && i == 0) chk("retry_gap_idle_cycles", 64'(n), 64'(GAPC));
        if (poke && a == 0 && i == 0) begin
          drv(); b.CMD_REQ = 1'b1;
          drv(); b.CMD_REQ = 1'b0;
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        if (res[a] == 3 && fw[a] == i) begin
          drv(); b.TX_FAIL = 1'b1;
          mid = 1;
        end else begin
          drv(); b.TX_ACK = 1'b1;
          wait_sig(1, "req_drop", n);
          repeat ($urandom_range(0, 2)) @(negedge clk);
          drv(); b.TX_ACK = 1'b0;
        end
      end
      if (!mid) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        drv();
        b.TX_SUCC = res[a] == 0 || res[a] == 2;
        b.TX_FAIL = res[a] != 0;
      end
      wait_sig(2, "resp_ack", n);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      drv(); b.TX_SUCC = 1'b0; b.TX_FAIL = 1'b0;
      wait_sig(3, "resp_ack_drop", n);
    end
    exp_on = 1'b0;
    repeat (3) @(negedge clk);
    chk("cmd_ack_count", 64'(n_ack - a0), 64'(1));
    chk("cmd_done_count", 64'(n_done - d0), 64'(ok));
    chk("cmd_err_count", 64'(n_err - e0), 64'(!ok));
    chk("word_request_count", 64'(n_rise - r0), 64'(rises));
    chk("busy_after_cmd", 64'(b.BUSY), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, len, d0, e0, r;
    int res [3];
    int fw [3];
    logic [4*DW-1:0] data;
    b.CMD_REQ = 1'b0; b.CMD_LEN = '0; b.CMD_DATA = '0; b.CMD_PRIORITY = 1'b0;
    b.TX_ACK = 1'b0; b.TX_SUCC = 1'b0; b.TX_FAIL = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs",
        64'({b.CMD_ACK, b.CMD_DONE, b.CMD_ERR, b.BUSY, b.TX_PEND, b.TX_REQ, b.TX_PRIORITY, b.TX_RESP_ACK}), 64'(0));
    chk("reset_tx_data", 64'(b.TX_DATA), 64'(0));
    chk("tx_addr_const", 64'(b.TX_ADDR), 64'(8'h01));
    drv(); rstn = 1'b1;
    repeat (2) @(negedge clk);

    run_cmd(0, {96'd0, 32'hA5A5_0001}, 1'b0, '{0, 0, 0}, '{0, 0, 0}, 0);
    chk("lit_done_after_1word", 64'(n_done), 64'(1));
    run_cmd(3, {32'd4, 32'd3, 32'd2, 32'd1}, 1'b1, '{0, 0, 0}, '{0, 0, 0}, 0);
    chk("lit_rises_after_4word", 64'(n_rise), 64'(5));
    run_cmd(0, {96'd0, 32'h0000_BEEF}, 1'b0, '{1, 0, 0}, '{0, 0, 0}, 0);
    chk("lit_done_after_retry", 64'(n_done), 64'(3));
    chk("lit_no_err_yet", 64'(n_err), 64'(0));
    run_cmd(0, {96'd0, 32'h0000_0BAD}, 1'b1, '{1, 2, 3}, '{0, 0, 0}, 1);
    chk("lit_err_after_exhaust", 64'(n_err), 64'(1));
    chk("lit_rises_after_exhaust", 64'(n_rise), 64'(10));
    chk("lit_acks_total", 64'(n_ack), 64'(4));

    // reset while the third word is being offered
    d0 = n_done; e0 = n_err;
    data = {32'd40, 32'd30, 32'd20, 32'd10};
    exp_on = 1'b1; exp_pri = 1'b0;
    drv();
    b.CMD_REQ = 1'b1; b.CMD_LEN = 2'd3; b.CMD_DATA = data; b.CMD_PRIORITY = 1'b0;
    wait_sig(4, "cmd_ack_rst", n);
    drv(); b.CMD_REQ = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_data = data[i*DW +: DW];
      exp_pend = 1'b1;
      wait_sig(0, "tx_req_rst", n);
      drv(); b.TX_ACK = 1'b1;
      wait_sig(1, "req_drop_rst", n);
      drv(); b.TX_ACK = 1'b0;
    end
    exp_data = 32'd30;
    wait_sig(0, "tx_req_word2", n);
    drv(); rstn = 1'b0;
    #1;
    chk("reset_mid_outputs",
        64'({b.CMD_ACK, b.CMD_DONE, b.CMD_ERR, b.BUSY, b.TX_PEND, b.TX_REQ, b.TX_PRIORITY, b.TX_RESP_ACK}), 64'(0));
    chk("reset_mid_tx_data", 64'(b.TX_DATA), 64'(0));
    exp_on = 1'b0;
    repeat (3) @(negedge clk);
    drv(); rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_mid_no_done", 64'(n_done - d0), 64'(0));
    chk("reset_mid_no_err", 64'(n_err - e0), 64'(0));
    run_cmd(1, {64'd0, 32'h1234_5678, 32'h9ABC_DEF0}, 1'b1, '{0, 0, 0}, '{0, 0, 0}, 0);

    repeat (40) begin
      len = $urandom_range(0, 3);
      for (int a = 0; a < 3; a++) begin
        r = $urandom_range(0, 5);
        res[a] = r <= 2 ? 0 : r - 2;
        fw[a] = $urandom_range(0, len);
      end
      data = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_cmd(len, data, 1'($urandom()), res, fw, $urandom_range(0, 3) == 0);
    end

`ifdef MBUS_CTRL_BCAST_TIMEOUT_EN
    e0 = n_err;
    exp_on = 1'b1; exp_pri = 1'b0; exp_data = 32'h77; exp_pend = 1'b0;
    drv();
    b.CMD_REQ = 1'b1; b.CMD_LEN = 2'd0; b.CMD_DATA = {96'd0, 32'h77}; b.CMD_PRIORITY = 1'b0;
    wait_sig(4, "cmd_ack_tmo", n);
    drv(); b.CMD_REQ = 1'b0;
    wait_sig(0, "tx_req_tmo", n);
    wait_sig(5, "timeout_err", n);
    chk("timeout_cycles_after_send", 64'(n), 64'(TMO));
    exp_on = 1'b0;
    repeat (2) @(negedge clk);
    chk("timeout_err_count", 64'(n_err - e0), 64'(1));
    chk("timeout_busy", 64'(b.BUSY), 64'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
